sample_burst_fifo: RTL
======================

Name: sample_burst_fifo

Overview:
- Buffering stage directly upstream of the six-sample average block.
- Accepts one 32-bit sample per cycle on a valid/ready input. Stores samples in a circular buffer.
- Releases them as fixed-length bursts of BURST_LEN consecutive beats, so the downstream accumulator always sees a complete window without gaps.
- Reports occupancy, a sticky drop flag and a one-cycle burst-done pulse.

Parameters:
- WIDTH, 32, sample width in bits.
- DEPTH, 16, buffer entries; power of two, must be >= BURST_LEN.
- BURST_LEN, 6, beats per output burst; matches the average window.
- AF_LEVEL, 12, almost-full threshold; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  WIDTH  sample to store
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  buffer can accept; equals !full
- out_data  out  WIDTH  head-of-buffer sample
- out_valid  out  1  out_data valid; asserted only in BURST state
- out_ready  in  1  consumer accepts out_data this cycle
- count  out  $clog2(DEPTH)+1  entries currently stored
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- drop  out  1  sticky; a push was attempted while full
- burst_done  out  1  one-cycle pulse after the last beat of a burst

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values (immediate, asynchronous):
  - wr_ptr = rd_ptr = 0, count = 0.
  - State = IDLE, beat counter = 0.
  - out_valid = 0, burst_done = 0, drop = 0.
  - empty = 1, full = 0, in_ready = 1.
  - Memory contents are don't-care.
- Reset mid-burst aborts the burst; no burst_done is issued.
- Push:
  - Occurs when in_valid && in_ready.
  - Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH (natural wrap).
- Drop:
  - Set when in_valid && full; that sample is discarded.
  - drop stays 1 until reset.
  - A same-cycle pop does not rescue the push: in_ready reflects full at the start of the cycle, with no bypass.
- Pop:
  - Occurs when out_valid && out_ready.
  - rd_ptr increments modulo DEPTH.
  - out_data = mem[rd_ptr] combinationally, with first-word fall-through.
- count:
  - +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Never exceeds DEPTH or underflows.
- full, empty and in_ready are combinational from the registered count.
- State machine (registered state):
  - IDLE: out_valid = 0. When count >= BURST_LEN, go to BURST next cycle with beat = 0. The count check uses the registered count, so a push in the same cycle that reaches BURST_LEN enters BURST one cycle later.
  - BURST: out_valid = 1. beat increments on each pop. When a pop occurs with beat == BURST_LEN-1, go to DONE. Stall while out_ready = 0: out_data and out_valid hold.
  - DONE: burst_done = 1 for exactly this cycle, then return to IDLE. Back-to-back bursts therefore have a 2-cycle gap (DONE, IDLE evaluation).
- Burst guarantee: entering BURST requires BURST_LEN entries, so out_valid never asserts on an empty buffer during a burst.
- Pushes continue normally in every state.
- burst_done and all state outputs are registered. Latency from the push that completes a window to the first out_valid is 2 cycles.

Optional Feature:
- Macro: SAMPLE_BURST_FIFO_ALMOST_FULL_EN.
- Defined:
  - Adds output port almost_full (1 bit) = (count >= AF_LEVEL), combinational from count, reset value 0.
  - Upstream uses it for early throttling.
- Undefined:
  - Port and logic are absent; AF_LEVEL is unused.
  - All other behaviour is identical.

Test Plan:
- Assert rst mid-cycle with 5 entries stored -> count, out_valid, drop and burst_done go to 0 immediately; empty = 1 before the next clk edge.
- Push 10,20,30,40,50,60 on consecutive cycles, out_ready = 1 -> out_valid rises 2 cycles after the push of 60. out_data sequence is 10..60 on 6 consecutive cycles, burst_done pulses once, the average output reads 35.
- Push 6 samples, hold out_ready = 0 for 4 cycles in BURST, then release -> out_data holds 10 with out_valid = 1 throughout the stall, count stays 6, then drains in order.
- Push 17 samples with no pops (DEPTH = 16) -> full = 1, in_ready = 0 at count 16, 17th sample discarded, drop = 1 and stays set after draining.
- Sustained push and pop across 40 samples -> pointers wrap past 15 with data order preserved. count stays constant on simultaneous push and pop cycles. burst_done pulses every 6 pops.
- With SAMPLE_BURST_FIFO_ALMOST_FULL_EN: push 12 samples -> almost_full rises when count = 12 and falls when count drops to 11.

Source files
------------

// File: rtl/sample_burst_fifo.sv
// Circular sample buffer that releases fixed BURST_LEN-beat bursts to the averager.
// Optional almost_full output: define SAMPLE_BURST_FIFO_ALMOST_FULL_EN.
module sample_burst_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 6,
  parameter int AF_LEVEL  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop,
`ifdef SAMPLE_BURST_FIFO_ALMOST_FULL_EN
  output logic                       almost_full,
`endif
  output logic                       burst_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST_LEN + 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  if (BURST_LEN > DEPTH || AF_LEVEL > DEPTH) begin : g_param_chk
    $error("sample_burst_fifo: BURST_LEN and AF_LEVEL must not exceed DEPTH");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  state_t           state, state_nxt;
  logic [BW-1:0]    beat, beat_nxt;
  logic             push, pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  // No bypass: a pop in the same cycle never makes room for a push to a full buffer.
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];
  assign out_valid = (state == BURST);
  assign burst_done = (state == DONE);

`ifdef SAMPLE_BURST_FIFO_ALMOST_FULL_EN
  assign almost_full = (count >= CW'(AF_LEVEL));
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (in_valid && full) drop <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // A burst only starts with a full window stored, so it can never run dry mid-burst.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      IDLE: begin
        if (count >= CW'(BURST_LEN)) begin
          state_nxt = BURST;
          beat_nxt  = '0;
        end
      end
      BURST: begin
        if (pop) begin
          if (beat == BW'(BURST_LEN - 1)) begin
            state_nxt = DONE;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
endmodule
